// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer bank: register offsets, CTRL bit layout,
// mode encodings and the per-channel FSM state type.
package timer_bank_pkg;

  localparam logic [31:0] OFF_CTRL   = 32'h0;
  localparam logic [31:0] OFF_PRESET = 32'h4;
  localparam logic [31:0] OFF_COUNT  = 32'h8;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM       = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CNT    = 2'd2,
    ST_EXPIRE = 2'd3
  } ch_state_e;

endpackage

// File: rtl/timer_bank_channel.sv
// One countdown timer channel: CTRL/PRESET/COUNT registers and the
// IDLE/LOAD/CNT/EXPIRE sequencer. `state` is the observable FSM state.
module timer_channel
  import timer_bank_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        ctrl_we,
  input  logic        preset_we,
  input  logic [31:0] wd,
  output logic [3:0]  ctrl,
  output logic [31:0] preset,
  output logic [31:0] count,
  output logic        expire
);

  ch_state_e state;
  ch_state_e state_d;
  logic      en;
  logic      reload;

  assign en     = ctrl[CTRL_EN];
  // MODE 1x behaves as one-shot, so only the exact reload code reloads.
  assign reload = (ctrl[CTRL_MODE_LSB +: 2] == MODE_RELOAD);
  assign expire = (state == ST_EXPIRE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (en) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_CNT;
      ST_CNT: begin
        if (!en)              state_d = ST_IDLE;
        else if (count == '0) state_d = ST_EXPIRE;
      end
      ST_EXPIRE: state_d = reload ? ST_LOAD : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl   <= '0;
      preset <= '0;
      count  <= '0;
    end else begin
      // A CPU CTRL write in the expire cycle takes precedence over auto-clear of EN.
      if (ctrl_we)
        ctrl <= wd[3:0];
      else if (expire && !reload)
        ctrl[CTRL_EN] <= 1'b0;

      if (preset_we)
        preset <= wd;

      if (state == ST_LOAD)
        count <= preset;
      else if (state == ST_CNT && en && tick && count != '0)
        count <= count - 32'd1;
    end
  end

endmodule

// File: rtl/timer_bank.sv
// Bank of NUM_CH countdown timers on the Pr* bus: address decode, shared
// prescaler, sticky write-1-to-clear STATUS and per-channel irq lines.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int          NUM_CH    = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter logic [31:0] CH_STRIDE = 32'h10,
  parameter int          PRESCALE  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [29:0]       pr_addr,
  input  logic              pr_we,
  input  logic [31:0]       pr_wd,
  output logic [31:0]       pr_rd,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  localparam logic [31:0] STATUS_OFF = 32'(NUM_CH) * CH_STRIDE;
  localparam logic [31:0] TICK_LAST  = 32'(PRESCALE - 1);

  logic [31:0]       byte_addr;
  logic [31:0]       offset;
  logic [31:0]       pre_cnt;
  logic              tick;
  logic              status_we;
  logic [NUM_CH-1:0] ctrl_we;
  logic [NUM_CH-1:0] preset_we;
  logic [NUM_CH-1:0] expire;
  logic [NUM_CH-1:0] im;
  logic [NUM_CH-1:0] pending;
  logic [3:0]        ch_ctrl   [NUM_CH];
  logic [31:0]       ch_preset [NUM_CH];
  logic [31:0]       ch_count  [NUM_CH];

  // Addresses below BASE_ADDR wrap to huge offsets and so match no register.
  assign byte_addr = {pr_addr, 2'b00};
  assign offset    = byte_addr - BASE_ADDR;

  always_comb begin
    ctrl_we   = '0;
    preset_we = '0;
    status_we = 1'b0;
    pr_rd     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (offset == 32'(i) * CH_STRIDE + OFF_CTRL) begin
        ctrl_we[i] = pr_we;
        pr_rd      = {28'd0, ch_ctrl[i]};
      end
      if (offset == 32'(i) * CH_STRIDE + OFF_PRESET) begin
        preset_we[i] = pr_we;
        pr_rd        = ch_preset[i];
      end
      if (offset == 32'(i) * CH_STRIDE + OFF_COUNT)
        pr_rd = ch_count[i];
    end
    if (offset == STATUS_OFF) begin
      status_we = pr_we;
      pr_rd     = 32'(pending);
    end
  end

  // With PRESCALE=1 the counter sits at 0 == TICK_LAST, holding tick high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 32'd1;
  end

  assign tick = (pre_cnt == TICK_LAST);

  // Expire sets a bit even when the same cycle's STATUS write clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      pending <= '0;
    else
      pending <= expire | (pending & ~({NUM_CH{status_we}} & pr_wd[NUM_CH-1:0]));
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .ctrl_we   (ctrl_we[i]),
      .preset_we (preset_we[i]),
      .wd        (pr_wd),
      .ctrl      (ch_ctrl[i]),
      .preset    (ch_preset[i]),
      .count     (ch_count[i]),
      .expire    (expire[i])
    );
    assign im[i] = ch_ctrl[i][CTRL_IM];
  end

  assign irq     = pending & im;
  assign irq_any = |irq;

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Parametrised successor to the fixed pair of memory-mapped countdown timers behind the CPU bridge.
- NUM_CH identical timer channels in one block, each with its own address window; window base and stride are parameters.
- Adds one-shot and auto-reload modes, a shared prescaler, and a global sticky interrupt-status register with write-1-to-clear.
- Sits on the CPU's Pr* bus. Per-channel irq bits feed the HWInt vector.

Parameters:
- NUM_CH, 2, number of timer channels (1..8).
- BASE_ADDR, 32'h0000_7F00, byte address of channel 0 window.
- CH_STRIDE, 32'h10, byte spacing between channel windows.
- PRESCALE, 1, clk cycles per count tick (1 = every cycle; must be ≥1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pr_addr  in  30  word address [31:2] from the CPU bridge
- pr_we  in  1  write strobe, sampled at posedge clk
- pr_wd  in  32  write data
- pr_rd  out  32  read data, combinational from pr_addr
- irq  out  NUM_CH  per-channel interrupt: pending[i] & IM[i]
- irq_any  out  1  OR of irq

Behaviour:
- Register map, channel i at BASE_ADDR + i*CH_STRIDE:
  - +0x0 CTRL: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM. Other bits read 0.
  - +0x4 PRESET: R/W.
  - +0x8 COUNT: read-only; writes ignored.
- Global STATUS register at BASE_ADDR + NUM_CH*CH_STRIDE:
  - [NUM_CH-1:0] pending bits.
  - Writing 1 clears a bit; writing 0 has no effect.
- Unmapped offsets inside the block's range: reads return 0; writes ignored.
- Addresses outside the block's range: pr_rd = 0; no state change.
- Reset (reset=0, asynchronous): CTRL, PRESET, COUNT, pending, and the prescaler all go to 0; every FSM goes to IDLE; irq and irq_any read 0.
- Prescaler:
  - Free-running counter 0..PRESCALE-1 shared by all channels.
  - tick is asserted for one cycle when the counter equals PRESCALE-1.
  - With PRESCALE=1, tick is held at 1.
- Per-channel FSM, states IDLE, LOAD, CNT, EXPIRE:
  - IDLE: COUNT holds its value. Goes to LOAD when EN=1.
  - LOAD: COUNT<=PRESET unconditionally (no tick needed). Goes to CNT.
  - CNT:
    - EN=0 → IDLE, with COUNT frozen.
    - Otherwise, COUNT==0 → EXPIRE.
    - Otherwise, on tick, COUNT<=COUNT-1.
  - EXPIRE (one cycle): pending[i]<=1.
    - MODE one-shot: EN<=0, go to IDLE.
    - MODE auto-reload: go to LOAD.
- Latency:
  - CTRL write with EN=1 at edge t → LOAD during cycle t+1, COUNT=PRESET after edge t+2.
  - With PRESCALE=1 and PRESET=N: EXPIRE is entered N+1 cycles after LOAD; pending is visible the following cycle.
  - Auto-reload period is N+3 cycles.
- PRESET=0: LOAD → CNT → EXPIRE immediately; the mode still applies.
- Writing PRESET during CNT has no effect until the next LOAD.
- Writing CTRL during CNT updates MODE and IM immediately. EN=0 stops the channel.
- Rewriting EN=1 while in CNT does not reload COUNT.
- Same cycle, EXPIRE sets pending[i] and a STATUS write clears bit i: set wins.
- Same cycle, a CPU CTRL write and EXPIRE one-shot clearing EN: the CPU write wins.
- No arithmetic wrap: COUNT never decrements below 0.
- irq is a level. It stays high until the pending bit is cleared or IM is cleared.

Decomposition:
- Shared package holds:
  - Register offsets (CTRL=0, PRESET=4, COUNT=8).
  - CTRL bit positions.
  - MODE encodings.
  - FSM state encodings.
- Natural sub-module: timer_channel, instantiated NUM_CH times via generate.
  - Inputs: clk, reset, tick, channel-local write enables, pr_wd.
  - Outputs: ctrl, preset, count, expire pulse.
- The top level owns:
  - Address decode.
  - The pending/STATUS register.
  - The prescaler.
  - The read mux.

Test Plan:
- Reset mid-count. Channel 0 in CNT with COUNT=5, then pull reset low for half a cycle → COUNT=0, IDLE, irq=0 immediately (asynchronous); stays IDLE after reset is released.
- One-shot. PRESET0=3, CTRL0=0x9 (EN, IM, one-shot) → COUNT reads 3,2,1,0; irq[0]=1 five cycles after LOAD; CTRL0 reads 0x8; irq stays high until STATUS write 0x1, then irq[0]=0.
- Auto-reload with PRESCALE=1. PRESET1=2, CTRL1=0xB → pending[1] set every 5 cycles. Clear STATUS in the same cycle as the next expire → pending stays 1 (set wins).
- Prescaler. PRESCALE=4, PRESET0=2, one-shot → COUNT decrements only on every 4th cycle; expire about 8 cycles after LOAD.
- Mid-count control.
  - Write CTRL0=0 during CNT at COUNT=7 → COUNT holds 7, no irq.
  - Re-enable → reload from PRESET.
  - Write PRESET during CNT → the current count is unaffected.
- Decode boundaries.
  - Write to COUNT → ignored.
  - Write to BASE+0xC → ignored; reads 0.
  - Address below BASE_ADDR → pr_rd=0; no channel changes.
  - Channel 1 CTRL write does not touch channel 0.
